seq_match_window_counter: RTL and testbench
===========================================

Name: seq_match_window_counter

Overview:
- Downstream consumer of the 101 Moore sequence detector. Its Match input connects directly to the detector's Q output.
- Counts detections over fixed windows of WINDOW clock cycles and delivers one count report per window over a valid/ready handshake.
- Flags saturated windows and reports lost because the consumer stalled, so software or a downstream stage can monitor pattern density.

Parameters:
- CNT_W, 8, width of the per-window match count; the count saturates at 2^CNT_W-1.
- WINDOW, 16, window length in clock cycles; legal range is 2 to 65535.

Ports:
- Clk  input  1  clock; all logic is rising-edge.
- Rst  input  1  reset, asynchronous, active-high.
- En  input  1  counting enable; high means run windows, low means idle.
- Clr  input  1  synchronous clear of counters, report and sticky flags.
- Match  input  1  detection strobe from the sequence detector; each cycle it is high counts as one match.
- RptCnt  output  CNT_W  match count of the reported window.
- RptSat  output  1  the reported window's count saturated.
- RptValid  output  1  a report is pending.
- RptReady  input  1  consumer accepts the report.
- Lost  output  1  sticky flag: an unaccepted report was overwritten.
- Busy  output  1  high while in the RUN state.

Behaviour:
- Reset (Rst=1, asynchronous): state=IDLE, timer=0, wcnt=0, wsat=0, RptCnt=0, RptSat=0, RptValid=0, Lost=0, Busy=0.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN when En=1, evaluated at the clock edge. The first counted cycle is the cycle after entry.
  - RUN -> IDLE when En=0. The partial window is discarded: timer=0, wcnt=0, wsat=0. Any pending report and Lost are kept.
  - Busy=1 exactly when state=RUN.
- In IDLE, Match is ignored.
- In RUN, each cycle:
  - timer increments, wrapping from WINDOW-1 to 0.
  - wcnt increments when Match=1. If wcnt is already at max, it stays at max and wsat is set.
- Window close: in RUN with timer==WINDOW-1, at that clock edge:
  - RptCnt is loaded with the window count including that cycle's Match, saturated.
  - RptSat is loaded with the window's saturation status, including that cycle.
  - RptValid is set to 1.
  - wcnt, wsat and timer are cleared to 0.
- Report latency: RptValid rises one clock after the last cycle of the window.
- Handshake:
  - A report is transferred on a cycle with RptValid=1 and RptReady=1. RptValid drops next cycle unless a window closes on the same edge.
  - While RptValid=1 and RptReady=0, RptCnt and RptSat are held stable.
  - RptReady is ignored while RptValid=0.
- Simultaneous events:
  - Window close while RptValid=1 and RptReady=0: the report is overwritten with new data, RptValid stays 1, and Lost is set (sticky).
  - Window close while RptValid=1 and RptReady=1: the old report is accepted and the new one loads. RptValid stays 1 and Lost is not set.
  - En falling on the window-close cycle: state=IDLE takes priority, and that window's report is not generated.
- Clr (synchronous, priority over everything except Rst):
  - Clears timer, wcnt, wsat, RptCnt, RptSat, RptValid and Lost.
  - State becomes RUN if En=1, IDLE otherwise, with a fresh window starting the next cycle.
- Overlapping detector output: adjacent Match=1 cycles each count. No edge detection is performed.
- Reset asserted mid-window or mid-handshake: all outputs return to their reset values immediately.

Test Plan:
- Basic window:
  - Stimulus: Rst pulse, then En=1, RptReady=1, WINDOW=16, Match=1 on window cycles 3 and 9.
  - Required: RptValid=1 for one cycle, 1 clock after cycle 15, with RptCnt=2, RptSat=0. Next window with no matches reports RptCnt=0.
- Saturation:
  - Stimulus: CNT_W=3, WINDOW=16, Match held 1 for the whole window.
  - Required: RptCnt=7, RptSat=1. The next window with 2 matches reports RptCnt=2, RptSat=0.
- Backpressure and loss:
  - Stimulus: RptReady=0 across two window closes with counts 4 then 5.
  - Required: RptValid stays 1, RptCnt=4 is held until the second close, then changes to 5, and Lost=1. Raising RptReady for 1 cycle drops RptValid; Lost stays 1 until Clr.
- Accept on close:
  - Stimulus: RptReady=1 on exactly the window-close edge while a prior report is pending.
  - Required: the new count loads, RptValid stays 1, Lost=0.
- En drop mid-window:
  - Stimulus: En=0 at window cycle 10 after 3 matches, then En=1 again.
  - Required: no report is generated for that window, Busy=0 while idle. The new window starts from count 0, so 2 later matches report RptCnt=2.
- Async reset during pending report:
  - Stimulus: assert Rst between clock edges while RptValid=1 and Lost=1.
  - Required: all outputs go to 0 before the next edge. After release with En=1, the first report appears 17 clocks after the En sample.

Source files
------------

// File: rtl/seq_match_window_counter.sv
// Counts Match strobes over fixed WINDOW-cycle windows and offers one
// saturating count per window on a valid/ready report port.
module seq_match_window_counter #(
   parameter int CNT_W  = 8,
   parameter int WINDOW = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic             Clr,
   input  logic             Match,
   output logic [CNT_W-1:0] RptCnt,
   output logic             RptSat,
   output logic             RptValid,
   input  logic             RptReady,
   output logic             Lost,
   output logic             Busy
);

   localparam int              TW      = $clog2(WINDOW);
   localparam logic [TW-1:0]   T_LAST  = TW'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic             wsat_q, wsat_d;
   logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_sat_q, rpt_sat_d;
   logic             rpt_valid_q, rpt_valid_d;
   logic             lost_q, lost_d;

   // Window count and saturation including the current cycle's Match
   logic [CNT_W-1:0] cnt_nxt;
   logic             sat_nxt;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (Clr) begin
         state_d = En ? S_RUN : S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (En)  state_d = S_RUN;
            S_RUN:   if (!En) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      Busy = (state_q == S_RUN);
   end

   always_comb begin
      cnt_nxt = wcnt_q;
      sat_nxt = wsat_q;
      if (Match) begin
         if (wcnt_q == CNT_MAX) sat_nxt = 1'b1;
         else                   cnt_nxt = wcnt_q + 1'b1;
      end
   end

   always_comb begin
      timer_d     = timer_q;
      wcnt_d      = wcnt_q;
      wsat_d      = wsat_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_sat_d   = rpt_sat_q;
      rpt_valid_d = rpt_valid_q;
      lost_d      = lost_q;
      if (Clr) begin
         timer_d     = '0;
         wcnt_d      = '0;
         wsat_d      = 1'b0;
         rpt_cnt_d   = '0;
         rpt_sat_d   = 1'b0;
         rpt_valid_d = 1'b0;
         lost_d      = 1'b0;
      end else begin
         if (rpt_valid_q && RptReady) rpt_valid_d = 1'b0;
         if (state_q == S_RUN) begin
            if (!En) begin
               // Leaving RUN drops the partial window; a pending report survives
               timer_d = '0;
               wcnt_d  = '0;
               wsat_d  = 1'b0;
            end else if (timer_q == T_LAST) begin
               rpt_cnt_d   = cnt_nxt;
               rpt_sat_d   = sat_nxt;
               rpt_valid_d = 1'b1;
               if (rpt_valid_q && !RptReady) lost_d = 1'b1;
               timer_d = '0;
               wcnt_d  = '0;
               wsat_d  = 1'b0;
            end else begin
               timer_d = timer_q + 1'b1;
               wcnt_d  = cnt_nxt;
               wsat_d  = sat_nxt;
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         timer_q     <= '0;
         wcnt_q      <= '0;
         wsat_q      <= 1'b0;
         rpt_cnt_q   <= '0;
         rpt_sat_q   <= 1'b0;
         rpt_valid_q <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         timer_q     <= timer_d;
         wcnt_q      <= wcnt_d;
         wsat_q      <= wsat_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_sat_q   <= rpt_sat_d;
         rpt_valid_q <= rpt_valid_d;
         lost_q      <= lost_d;
      end
   end

   assign RptCnt   = rpt_cnt_q;
   assign RptSat   = rpt_sat_q;
   assign RptValid = rpt_valid_q;
   assign Lost     = lost_q;

endmodule

// File: tb/tb_seq_match_window_counter.sv
// Directed bench: per-window table of Match/RptReady masks with expected
// reports, plus hand sequences for Clr, En drop and async reset.
module tb_seq_match_window_counter;

   localparam int CNT_W  = 3;
   localparam int WINDOW = 16;

   logic             Clk = 1'b0;
   logic             Rst = 1'b0;
   logic             En = 1'b0;
   logic             Clr = 1'b0;
   logic             Match = 1'b0;
   logic             RptReady = 1'b0;
   logic [CNT_W-1:0] RptCnt;
   logic             RptSat, RptValid, Lost, Busy;

   seq_match_window_counter #(.CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
      .Clk(Clk), .Rst(Rst), .En(En), .Clr(Clr), .Match(Match),
      .RptCnt(RptCnt), .RptSat(RptSat), .RptValid(RptValid),
      .RptReady(RptReady), .Lost(Lost), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   // mtch/rdy bit i drives Match/RptReady during window cycle i
   typedef struct {
      logic [15:0]      mtch;
      logic [15:0]      rdy;
      logic [CNT_W-1:0] cnt;
      logic             sat;
      logic             lost;
   } win_t;

   win_t             tbl[14];
   int               ntests = 0;
   int               nfail = 0;
   logic             pend = 1'b0;
   logic [CNT_W-1:0] prev_cnt = '0;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_window(input int k);
      for (int i = 0; i < WINDOW; i++) begin
         RptReady = tbl[k].rdy[i];
         Match    = tbl[k].mtch[i];
         tick();
         if (i == 7 && pend && tbl[k].rdy[7:0] == 8'h00) begin
            chk($sformatf("w%0d hold valid", k), 32'(RptValid), 32'd1);
            chk($sformatf("w%0d hold cnt", k), 32'(RptCnt), 32'(prev_cnt));
         end
         if (i == WINDOW - 2 && (tbl[k].rdy[0] || !pend))
            chk($sformatf("w%0d early valid", k), 32'(RptValid), 32'd0);
      end
      Match = 1'b0;
      chk($sformatf("w%0d valid", k), 32'(RptValid), 32'd1);
      chk($sformatf("w%0d cnt", k), 32'(RptCnt), 32'(tbl[k].cnt));
      chk($sformatf("w%0d sat", k), 32'(RptSat), 32'(tbl[k].sat));
      chk($sformatf("w%0d lost", k), 32'(Lost), 32'(tbl[k].lost));
      chk($sformatf("w%0d busy", k), 32'(Busy), 32'd1);
      pend     = 1'b1;
      prev_cnt = tbl[k].cnt;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " cnt"}, 32'(RptCnt), 32'd0);
      chk({tag, " sat"}, 32'(RptSat), 32'd0);
      chk({tag, " valid"}, 32'(RptValid), 32'd0);
      chk({tag, " lost"}, 32'(Lost), 32'd0);
      chk({tag, " busy"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      int n;
      tbl[0]  = '{16'h0208, 16'hFFFF, 3'd2, 1'b0, 1'b0};  // cycles 3 and 9
      tbl[1]  = '{16'h0000, 16'hFFFF, 3'd0, 1'b0, 1'b0};
      tbl[2]  = '{16'hFFFF, 16'hFFFF, 3'd7, 1'b1, 1'b0};  // saturates
      tbl[3]  = '{16'h0120, 16'hFFFF, 3'd2, 1'b0, 1'b0};
      tbl[4]  = '{16'h0070, 16'hFFFF, 3'd3, 1'b0, 1'b0};  // adjacent matches
      tbl[5]  = '{16'h8000, 16'hFFFF, 3'd1, 1'b0, 1'b0};  // match on close cycle
      tbl[6]  = '{16'h007F, 16'hFFFF, 3'd7, 1'b0, 1'b0};  // exactly max
      tbl[7]  = '{16'h0F00, 16'h0001, 3'd4, 1'b0, 1'b0};
      tbl[8]  = '{16'h001F, 16'h0000, 3'd5, 1'b0, 1'b1};  // overwrite -> Lost
      tbl[9]  = '{16'h0101, 16'h0000, 3'd2, 1'b0, 1'b0};
      tbl[10] = '{16'h0007, 16'h8000, 3'd3, 1'b0, 1'b0};  // accept on close
      tbl[11] = '{16'h0240, 16'hFFFF, 3'd2, 1'b0, 1'b0};
      tbl[12] = '{16'h0001, 16'h0000, 3'd1, 1'b0, 1'b0};
      tbl[13] = '{16'h0003, 16'h0000, 3'd2, 1'b0, 1'b1};

      Rst = 1'b1;
      #12;
      chk_zero("reset");
      Rst = 1'b0;
      tick();
      chk("idle busy", 32'(Busy), 32'd0);

      En = 1'b1; RptReady = 1'b1;
      tick();
      chk("entry busy", 32'(Busy), 32'd1);
      for (int k = 0; k <= 8; k++) run_window(k);

      // One-cycle accept clears valid but not Lost; Clr clears Lost
      RptReady = 1'b1;
      tick();
      RptReady = 1'b0;
      chk("drain valid", 32'(RptValid), 32'd0);
      chk("drain lost", 32'(Lost), 32'd1);
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      chk("clr lost", 32'(Lost), 32'd0);
      chk("clr cnt", 32'(RptCnt), 32'd0);
      chk("clr busy", 32'(Busy), 32'd1);
      pend = 1'b0;
      for (int k = 9; k <= 10; k++) run_window(k);

      // En drop at window cycle 10 after three matches
      RptReady = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         Match = (i == 1 || i == 4 || i == 7);
         En    = (i < 10);
         tick();
      end
      chk("drop busy", 32'(Busy), 32'd0);
      Match = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("idle valid", 32'(RptValid), 32'd0);
      chk("idle busy2", 32'(Busy), 32'd0);
      Match = 1'b0; En = 1'b1;
      tick();
      pend = 1'b0;
      run_window(11);

      // En drop on the window-close cycle suppresses the report
      for (int i = 0; i < WINDOW; i++) begin
         Match = (i == 2);
         En    = (i < WINDOW - 1);
         tick();
      end
      chk("dropclose valid", 32'(RptValid), 32'd0);
      chk("dropclose busy", 32'(Busy), 32'd0);
      Match = 1'b0; En = 1'b1; RptReady = 1'b0;
      tick();
      pend = 1'b0;
      run_window(12);
      run_window(13);

      // Async reset between edges with a report pending and Lost set
      #3;
      Rst = 1'b1;
      #1;
      chk_zero("async rst");
      #2;
      Rst = 1'b0; En = 1'b1; RptReady = 1'b1; Match = 1'b0;
      n = 0;
      while (n < 40 && !RptValid) begin
         tick();
         n++;
      end
      chk("post-rst latency", 32'(n), 32'd17);
      chk("post-rst cnt", 32'(RptCnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
